// File: rtl/rf_dump_ctrl_pkg.sv
// rf_pkg: shared sizes and FSM state type for the register-file dump controller.
//   NREGS : number of registers walked by a dump
//   AW    : register index width
//   DW    : register data width
package rf_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// rf_dump_ctrl_if: valid/ready stream carrying dumped register words.
//   dump_valid : word valid (master -> slave)
//   dump_ready : consumer accepts word (slave -> master)
//   dump_idx   : register index of the word (master -> slave)
//   dump_data  : register contents (master -> slave)
interface rf_dump_ctrl_if #(
  parameter int unsigned AW = rf_pkg::AW,
  parameter int unsigned DW = rf_pkg::DW
);

  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );

endinterface

// File: rtl/rf_dump_ctrl.sv
// rf_dump_ctrl: sits between CPU write-back and the register file. On dump_req
// it stalls write-back and streams every register out over the dump channel,
// then releases the CPU.
//   clk, rst           : clock, synchronous active-high reset
//   dump_req           : start a dump (honoured only when idle)
//   cpu_we/waddr/wdata : CPU write-back port
//   rf_we/waddr/wdata  : register file write port (gated CPU write)
//   rf_raddr, rf_rdata : register file read port (combinational read)
//   dump               : dump word stream (master side)
//   stall              : CPU must hold write-back
//   done               : one-cycle pulse after the last word is accepted
//   err                : sticky, CPU attempted a write while stalled
module rf_dump_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned AW    = rf_pkg::AW,
  parameter int unsigned DW    = rf_pkg::DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_req,
  input  logic                  cpu_we,
  input  logic [AW-1:0]         cpu_waddr,
  input  logic [DW-1:0]         cpu_wdata,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic [AW-1:0]         rf_raddr,
  input  logic [DW-1:0]         rf_rdata,
  rf_dump_ctrl_if.master        dump,
  output logic                  stall,
  output logic                  done,
  output logic                  err
);

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic          valid_q;
  logic [AW-1:0] idx_q;
  logic [DW-1:0] data_q;
  logic          last;

  assign last = (idx == AW'(NREGS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_req) state_nxt = READ;
      READ:    state_nxt = SEND;
      SEND:    if (dump.dump_ready) state_nxt = last ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (dump_req) idx <= '0;
        READ: begin
          data_q  <= rf_rdata;
          idx_q   <= idx;
          valid_q <= 1'b1;
        end
        SEND: if (dump.dump_ready) begin
          valid_q <= 1'b0;
          // The counter parks on the last index instead of wrapping.
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
      if (cpu_we && stall) err <= 1'b1;
    end
  end

  assign stall    = (state != IDLE);
  assign done     = (state == DONE);
  assign rf_raddr = idx;

  // In the IDLE cycle that carries dump_req stall is still low, so a
  // simultaneous write lands before the walk reads register 0.
  assign rf_we    = cpu_we & ~stall;
  assign rf_waddr = cpu_waddr;
  assign rf_wdata = cpu_wdata;

  assign dump.dump_valid = valid_q;
  assign dump.dump_idx   = idx_q;
  assign dump.dump_data  = data_q;

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// tb_rf_dump_ctrl: randomized self-checking bench for rf_dump_ctrl with a
// word-level reference model and a behavioural register file.
module tb_rf_dump_ctrl;
  import rf_pkg::*;

  logic          clk = 1'b0;
  logic          rst, dump_req, cpu_we;
  logic [AW-1:0] cpu_waddr, rf_waddr, rf_raddr;
  logic [DW-1:0] cpu_wdata, rf_wdata, rf_rdata;
  logic          rf_we, stall, done, err;

  rf_dump_ctrl_if #(.AW(AW), .DW(DW)) dif ();

  rf_dump_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .dump      (dif),
    .stall     (stall),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Register file behind the controller: combinational read, clocked write.
  logic [DW-1:0] rf [NREGS];
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk) if (rf_we) rf[rf_waddr] <= rf_wdata;

  int unsigned ncmp = 0;
  int unsigned nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is a list of NREGS words; each word takes one
  // read cycle, is then presented until accepted; after the last acceptance
  // there is one done cycle. Writes are honoured only when not busy.
  int unsigned   cyc = 0;
  bit            armed = 0;
  logic [DW-1:0] m_rf [NREGS];
  bit            m_busy, m_read, m_valid, m_done, m_err;
  int unsigned   m_k;
  logic [AW-1:0] m_oidx;
  logic [DW-1:0] m_odata;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      armed = 1; m_busy = 0; m_read = 0; m_valid = 0; m_done = 0; m_err = 0; m_k = 0;
    end else begin
      if (cpu_we) begin
        if (!m_busy) m_rf[cpu_waddr] = cpu_wdata;
        else m_err = 1;
      end
      if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (!m_busy) begin
        if (dump_req) begin m_busy = 1; m_read = 1; m_k = 0; end
      end else if (m_read) begin
        m_read = 0; m_valid = 1; m_oidx = AW'(m_k); m_odata = m_rf[m_k];
      end else if (m_valid && dif.dump_ready) begin
        m_valid = 0;
        if (m_k == NREGS - 1) m_done = 1;
        else begin m_k++; m_read = 1; end
      end
    end
  end

  // Per-dump statistics used by the literal checks.
  int unsigned   start_cyc, first_valid, done_cyc, stall_low, words, done_cnt;
  int            first_idx;
  logic [DW-1:0] w5;

  task automatic clear_stats();
    first_valid = 0; done_cyc = 0; stall_low = 0; words = 0; done_cnt = 0;
    first_idx = -1; w5 = '0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("stall",  32'(stall), 32'(m_busy));
      chk("done",   32'(done),  32'(m_done));
      chk("err",    32'(err),   32'(m_err));
      chk("valid",  32'(dif.dump_valid), 32'(m_valid));
      chk("rf_we",  32'(rf_we), 32'(cpu_we & ~m_busy));
      chk("raddr",  32'(rf_raddr), m_k);
      if (m_valid) begin
        chk("dump_idx",  32'(dif.dump_idx),  32'(m_oidx));
        chk("dump_data", 32'(dif.dump_data), 32'(m_odata));
      end
      if (dif.dump_valid && first_valid == 0) first_valid = cyc - start_cyc + 1;
      if (dif.dump_valid && first_idx < 0) first_idx = int'(dif.dump_idx);
      if (dif.dump_valid && dif.dump_idx == AW'(5)) w5 = dif.dump_data;
      if (dif.dump_valid && dif.dump_ready) words++;
      if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc - start_cyc + 1; end
      if (done_cyc != 0 && !stall && stall_low == 0) stall_low = cyc - start_cyc + 1;
    end
  end

  // dump_ready driver: 0 = always ready, 1 = ready one cycle in three, 2 = random.
  int          rmode = 0;
  int unsigned rc = 0;
  initial begin
    dif.dump_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      case (rmode)
        0:       dif.dump_ready = 1'b1;
        1:       dif.dump_ready = (rc % 3 == 0);
        default: dif.dump_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit rand_wr = 0;

  task automatic step();
    @(posedge clk); #1;
    if (rand_wr) begin
      cpu_we    = ($urandom_range(0, 5) == 0);
      cpu_waddr = AW'($urandom);
      cpu_wdata = $urandom;
    end else begin
      cpu_we = 1'b0;
    end
  endtask

  task automatic preload();
    for (int i = 0; i < int'(NREGS); i++) begin
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_waddr = AW'(i); cpu_wdata = DW'(i * 3);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  // Call at posedge+1; the following edge is edge 0 of the dump.
  task automatic pulse_req();
    clear_stats();
    start_cyc = cyc + 1;
    dump_req  = 1'b1;
    @(posedge clk); #1;
    dump_req  = 1'b0;
    cpu_we    = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    if (done_cnt == 0) chk("done_timeout", 32'(done_cnt), 32'd1);
    rand_wr = 0;
    repeat (3) step();
  endtask

  task automatic wait_word(input int unsigned k, input string name);
    int unsigned n = 0;
    while (!(dif.dump_valid && dif.dump_idx == AW'(k)) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 400) chk(name, 32'(dif.dump_idx), k);
  endtask

  initial begin
    rst = 1'b1; dump_req = 1'b0; cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(dif.dump_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_raddr", 32'(rf_raddr), 32'd0);
    chk("rst_data",  32'(dif.dump_data), 32'd0);

    // Full dump with ready held high: timing pinned to literal cycles.
    rmode = 0;
    preload();
    pulse_req();
    wait_done(200);
    chk("t1_first_valid", first_valid, 32'd2);
    chk("t1_done_cycle",  done_cyc,    32'd65);
    chk("t1_stall_low",   stall_low,   32'd66);
    chk("t1_words",       words,       32'd32);
    chk("t1_done_cnt",    done_cnt,    32'd1);

    // Backpressure one-in-three.
    rmode = 1;
    @(posedge clk); #1;
    pulse_req();
    wait_done(400);
    chk("t2_words",    words,    32'd32);
    chk("t2_done_cnt", done_cnt, 32'd1);

    // Write coincident with dump_req lands first.
    rmode = 0;
    cpu_we = 1'b1; cpu_waddr = AW'(5); cpu_wdata = 32'hDEAD;
    pulse_req();
    wait_done(200);
    chk("t3_word5", w5,         32'hDEAD);
    chk("t3_err",   32'(err),   32'd0);

    // Write during SEND of word 7 is dropped and flagged.
    pulse_req();
    wait_word(7, "t4_wait7");
    cpu_we = 1'b1; cpu_waddr = AW'(7); cpu_wdata = 32'hBAD;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    wait_done(200);
    chk("t4_rf7",  rf[7],      32'd21);
    chk("t4_err",  32'(err),   32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4_err_clr", 32'(err), 32'd0);

    // Reset mid-dump at word 10, then restart.
    @(posedge clk); #1;
    pulse_req();
    wait_word(10, "t5_wait10");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 32'(dif.dump_valid), 32'd0);
    chk("t5_stall", 32'(stall), 32'd0);
    repeat (70) step();
    chk("t5_no_done", done_cnt, 32'd0);
    pulse_req();
    wait_done(200);
    chk("t5_first_idx", 32'(first_idx), 32'd0);
    chk("t5_words",     words,          32'd32);

    // dump_req pulsed mid-dump is ignored.
    pulse_req();
    wait_word(15, "t6_wait15");
    dump_req = 1'b1;
    @(posedge clk); #1 dump_req = 1'b0;
    wait_done(200);
    repeat (5) step();
    chk("t6_words",    words,    32'd32);
    chk("t6_done_cnt", done_cnt, 32'd1);

    // Randomized traffic: random writes, random backpressure, writes during dumps.
    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      rand_wr = 1;
      repeat (40) step();
      pulse_req();
      rand_wr = 1;
      wait_done(1000);
      chk("rnd_words", words, 32'd32);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
